sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single SDRAM controller Avalon-MM slave between two requesters in the pong design. One is the display port, which performs VGA framebuffer line fetches: read-only, latency-critical, high priority. The other is the draw port, which handles game-logic sprite/paddle/ball rendering: reads and writes at low priority, with a starvation guard. The block registers the winning command onto a single downstream master and steers pipelined read data back to the originating port through an in-order tag FIFO.

## Interface
- ADDR_W, 24, word address width (13 row + 9 col + 2 bank)
- DATA_W, 16, data width; byteenable is DATA_W/8
- MAX_PENDING, 8, max outstanding downstream reads (tag FIFO depth, power of 2)
- STARVE_LIMIT, 16, consecutive lost captures before draw port is forced to win

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  asynchronous, active-low reset
- disp_address  in  ADDR_W  display read address
- disp_read  in  1  display read request
- disp_waitrequest  out  1  high = command not accepted this cycle
- disp_readdata  out  DATA_W  returned data
- disp_readdatavalid  out  1  one-cycle strobe per returned word
- draw_address  in  ADDR_W  draw address
- draw_read, draw_write  in  1 each  draw command; both high is treated as write
- draw_writedata  in  DATA_W; draw_byteenable  in  DATA_W/8
- draw_waitrequest, draw_readdatavalid  out  1 each; draw_readdata  out  DATA_W
- m_address  out  ADDR_W; m_read, m_write  out  1; m_writedata  out  DATA_W; m_byteenable  out  DATA_W/8
- m_waitrequest, m_readdatavalid  in  1; m_readdata  in  DATA_W
- rd_underflow  out  1  sticky error: readdatavalid with no read outstanding

## Operation
- Command register (CR) holds one command driving m_*. CR is free when it is empty, or when it holds a command and m_waitrequest=0 this cycle (accept-and-refill in the same cycle).
- Capture: when CR is free, pick a winner among requesting ports; that port's waitrequest=0 this cycle and its command loads CR at the edge. Non-winners' waitrequest=1. Waitrequest is 1 whenever CR is not free.
- Priority: display wins by default. starve_cnt increments each cycle draw requests and does not capture, saturating at STARVE_LIMIT. When starve_cnt==STARVE_LIMIT, draw wins the next capture. starve_cnt clears on draw capture or when draw is not requesting.
- Read gating: a read (either port) may not capture when outstanding count == MAX_PENDING. In that case draw writes may still win, and a display read waits.
- Tag FIFO: push the port id (0=disp, 1=draw) when a read command is accepted downstream (m_read=1, m_waitrequest=0). Pop on m_readdatavalid. Push and pop may occur in the same cycle; count is unchanged.
- Return: at the edge after m_readdatavalid, the popped id's readdatavalid=1 for one cycle and its readdata=registered m_readdata. The other port's valid=0.
- m_readdatavalid with the FIFO empty: data dropped, rd_underflow set until reset.
- Write commands push nothing; writedata/byteenable are captured into CR. For reads, m_writedata/m_byteenable hold their last value and are don't-care.
- Outstanding count includes reads in CR not yet accepted, so the gate is exact: count = FIFO occupancy + (CR holds read).

## Timing
- Reset (async assert, sync release): CR empty, m_read=m_write=0, m_address/m_writedata/m_byteenable=0, both upstream waitrequest=1, readdatavalid=0, readdata=0, FIFO empty, starve_cnt=0, rd_underflow=0.
- Reset mid-operation flushes CR and the FIFO. The SDRAM controller shares reset_reset_n, so no stale returns are expected.
- Capture cycle N means m_read/m_write is high from N+1 and held stable until accepted.
- With m_waitrequest permanently 0, throughput is one command per cycle.
- Upstream read latency = downstream latency + 2 cycles (CR stage + return register).
- Returns are strictly in order of downstream acceptance.

## Test plan
- Display-only stream, m_waitrequest=0, controller latency 3: 8 reads at addresses 0x000100..0x000107 → m_address sequence identical, one per cycle; disp_readdatavalid 5 cycles after each capture; data in order; draw_readdatavalid never asserted.
- Both ports request continuously, STARVE_LIMIT=16: exactly 1 draw capture per 17 captures; starve_cnt resets after each draw win.
- Backpressure: m_waitrequest held high 4 cycles with a draw write 0xBEEF, byteenable 2'b01 → m_* stable all 4 cycles; both waitrequests=1; capture of the next command occurs in the accept cycle.
- Pending limit: controller withholds readdatavalid; 8 reads accepted → 9th display read stalls (disp_waitrequest=1) while a draw write still issues; first return releases the stall.
- Interleaved reads disp/draw/disp → readdatavalid steered 0,1,0 with matching data; spurious m_readdatavalid on an empty FIFO → rd_underflow=1 and stays 1.
- Assert reset_reset_n=0 with 3 reads outstanding and CR full → all outputs at reset values immediately (asynchronously); after release, a fresh display read completes normally.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM style command/response bundle shared by the display port, the draw
// port and the downstream SDRAM master of sdram_port_arbiter.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  // master issues commands; slave answers with waitrequest and read returns
  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller: display reads win by
// default, draw reads/writes win after STARVE_LIMIT lost captures.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int MAX_PENDING  = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  sdram_port_arbiter_if.slave  disp,
  sdram_port_arbiter_if.slave  draw,
  sdram_port_arbiter_if.master m,
  output logic                 rd_underflow
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic TAG_DISP = 1'b0;
  localparam logic TAG_DRAW = 1'b1;

  typedef enum logic [1:0] {CR_EMPTY, CR_READ, CR_WRITE} cr_state_t;

  cr_state_t         r_cr_state, w_cr_next;
  logic              r_cr_tag;
  logic [ADDR_W-1:0] r_m_address;
  logic [DATA_W-1:0] r_m_writedata;
  logic [BE_W-1:0]   r_m_byteenable;
  logic              r_ready;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_tag_mem [MAX_PENDING];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic              r_disp_rdv, r_draw_rdv, r_underflow;
  logic [DATA_W-1:0] r_rdata;

  logic             w_cr_free, w_rd_ok, w_disp_can, w_draw_req, w_draw_can;
  logic             w_force, w_grant_ok, w_draw_win, w_disp_win;
  logic             w_push, w_pop, w_fifo_empty, w_pop_tag;
  logic [CNT_W-1:0] w_outstanding;
  logic             w_unused;

  // Handshake: a requester holds its command until it sees waitrequest=0 in a
  // cycle; that cycle is the capture and the command is in CR after the edge.
  // Downstream, CR is presented until m.waitrequest=0, and the same cycle may
  // refill CR with the next winner.
  always_comb begin
    w_cr_free     = (r_cr_state == CR_EMPTY) || !m.waitrequest;
    // reads sitting in CR count as outstanding so the gate never over-issues
    w_outstanding = r_fifo_cnt + CNT_W'(r_cr_state == CR_READ);
    w_rd_ok       = (w_outstanding != CNT_W'(MAX_PENDING));
    w_disp_can    = disp.read && w_rd_ok;
    w_draw_req    = draw.read || draw.write;
    w_draw_can    = w_draw_req && (draw.write || w_rd_ok);
    w_force       = (r_starve_cnt == SC_W'(STARVE_LIMIT));
    w_grant_ok    = r_ready && w_cr_free;
    w_draw_win    = w_grant_ok && w_draw_can && (w_force || !w_disp_can);
    w_disp_win    = w_grant_ok && w_disp_can && !w_draw_win;

    w_cr_next = r_cr_state;
    if (w_cr_free) begin
      if (w_draw_win)      w_cr_next = draw.write ? CR_WRITE : CR_READ;
      else if (w_disp_win) w_cr_next = CR_READ;
      else                 w_cr_next = CR_EMPTY;
    end

    w_push       = (r_cr_state == CR_READ) && !m.waitrequest;
    w_fifo_empty = (r_fifo_cnt == '0);
    w_pop        = m.readdatavalid && !w_fifo_empty;
    w_pop_tag    = r_tag_mem[r_rd_ptr];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_cr_state <= CR_EMPTY;
    else                r_cr_state <= w_cr_next;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cr_tag       <= TAG_DISP;
      r_m_address    <= '0;
      r_m_writedata  <= '0;
      r_m_byteenable <= '0;
    end else if (w_draw_win) begin
      r_cr_tag    <= TAG_DRAW;
      r_m_address <= draw.address;
      if (draw.write) begin
        r_m_writedata  <= draw.writedata;
        r_m_byteenable <= draw.byteenable;
      end
    end else if (w_disp_win) begin
      r_cr_tag    <= TAG_DISP;
      r_m_address <= disp.address;
    end
  end

  // r_ready keeps both waitrequests high until the first edge after reset
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ready      <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_draw_req && !w_draw_win) begin
        if (!w_force) r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_cr_tag;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_disp_rdv  <= 1'b0;
      r_draw_rdv  <= 1'b0;
      r_rdata     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_disp_rdv <= w_pop && (w_pop_tag == TAG_DISP);
      r_draw_rdv <= w_pop && (w_pop_tag == TAG_DRAW);
      if (w_pop) r_rdata <= m.readdata;
      if (m.readdatavalid && w_fifo_empty) r_underflow <= 1'b1;
    end
  end

  assign m.address    = r_m_address;
  assign m.read       = (r_cr_state == CR_READ);
  assign m.write      = (r_cr_state == CR_WRITE);
  assign m.writedata  = r_m_writedata;
  assign m.byteenable = r_m_byteenable;

  assign disp.waitrequest   = !w_disp_win;
  assign disp.readdata      = r_rdata;
  assign disp.readdatavalid = r_disp_rdv;
  assign draw.waitrequest   = !w_draw_win;
  assign draw.readdata      = r_rdata;
  assign draw.readdatavalid = r_draw_rdv;
  assign rd_underflow       = r_underflow;

  // the display port is read-only; its write-side bundle signals are ignored
  assign w_unused = &{1'b0, disp.write, disp.writedata, disp.byteenable};
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: port drivers, a latency-3 SDRAM controller
// model, and command/return scoreboards fed at upstream capture.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;
  localparam int LAT    = 3;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  typedef struct packed {
    logic [31:0]       due;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic clk_clk;
  logic reset_reset_n;
  logic rd_underflow;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) disp_if ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) draw_if ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(8), .STARVE_LIMIT(16)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .disp         (disp_if),
    .draw         (draw_if),
    .m            (m_if),
    .rd_underflow (rd_underflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  // ---------------- shared state ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   n_disp_cap = 0;
  int   n_draw_cap = 0;
  int   n_rdv = 0;
  bit   mwait = 0;
  bit   hold = 0;
  bit   spurious = 0;
  bit   lat_chk = 0;
  bit   disp_busy = 0;
  bit   draw_busy = 0;
  cmd_t disp_cur, draw_cur;

  cmd_t disp_q[$];
  cmd_t draw_q[$];
  cmd_t exp_cmd_q[$];
  logic [DATA_W:0] exp_q[$];
  ret_t pend_q[$];
  int   lat_q[$];
  int   disp_cap_cyc[$];
  logic cap_log[$];
  logic rdv_log[$];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers, controller model, scoreboard ----------------
  initial begin : bus_proc
    logic [DATA_W:0] e;
    int   l;
    cmd_t c;
    ret_t r;
    disp_if.read = 0; disp_if.write = 0; disp_if.address = '0;
    disp_if.writedata = '0; disp_if.byteenable = '0;
    draw_if.read = 0; draw_if.write = 0; draw_if.address = '0;
    draw_if.writedata = '0; draw_if.byteenable = '0;
    m_if.waitrequest = 0; m_if.readdatavalid = 0; m_if.readdata = '0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        disp_q.delete(); draw_q.delete(); exp_cmd_q.delete(); exp_q.delete();
        pend_q.delete(); lat_q.delete();
        disp_busy = 0; draw_busy = 0;
      end else begin
        if (disp_if.read && !disp_if.waitrequest) begin
          exp_cmd_q.push_back(disp_cur);
          exp_q.push_back({1'b0, mem_word(disp_cur.addr)});
          lat_q.push_back(cyc);
          disp_cap_cyc.push_back(cyc);
          cap_log.push_back(1'b0);
          n_disp_cap++;
          disp_busy = 0;
        end
        if ((draw_if.read || draw_if.write) && !draw_if.waitrequest) begin
          check_eq("single_grant", disp_if.read && !disp_if.waitrequest, 0);
          exp_cmd_q.push_back(draw_cur);
          if (!draw_cur.wr) begin
            exp_q.push_back({1'b1, mem_word(draw_cur.addr)});
            lat_q.push_back(cyc);
          end
          cap_log.push_back(1'b1);
          n_draw_cap++;
          draw_busy = 0;
        end
        if ((m_if.read || m_if.write) && !m_if.waitrequest) begin
          check_eq("m_cmd_expected", exp_cmd_q.size() != 0, 1);
          if (exp_cmd_q.size() != 0) begin
            c = exp_cmd_q.pop_front();
            check_eq("m_rw", {m_if.write, m_if.read}, {c.wr, !c.wr});
            check_eq("m_address", m_if.address, c.addr);
            if (c.wr) check_eq("m_wdata_be", {m_if.writedata, m_if.byteenable}, {c.wdata, c.be});
          end
          if (m_if.read) pend_q.push_back('{due: cyc + LAT, data: mem_word(m_if.address)});
        end
        if (disp_if.readdatavalid || draw_if.readdatavalid) begin
          n_rdv++;
          check_eq("rdv_one_hot", disp_if.readdatavalid && draw_if.readdatavalid, 0);
          check_eq("rdv_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            check_eq("rdv_port", draw_if.readdatavalid, e[DATA_W]);
            check_eq("rdv_data", draw_if.readdatavalid ? draw_if.readdata : disp_if.readdata,
                     e[DATA_W-1:0]);
            if (lat_chk) check_eq("rd_latency", cyc - l, 5);
            rdv_log.push_back(draw_if.readdatavalid);
          end
        end
      end
      @(posedge clk_clk);
      cyc++;
      #1;
      m_if.waitrequest = mwait;
      if (spurious) begin
        m_if.readdatavalid = 1'b1;
        m_if.readdata      = 16'hDEAD;
      end else if (!hold && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        m_if.readdatavalid = 1'b1;
        m_if.readdata      = r.data;
      end else begin
        m_if.readdatavalid = 1'b0;
        m_if.readdata      = 16'($urandom);
      end
      if (!disp_busy && disp_q.size() != 0) begin
        disp_cur  = disp_q.pop_front();
        disp_busy = 1;
      end
      disp_if.read    = disp_busy;
      disp_if.address = disp_cur.addr;
      if (!draw_busy && draw_q.size() != 0) begin
        draw_cur  = draw_q.pop_front();
        draw_busy = 1;
      end
      draw_if.read       = draw_busy && !draw_cur.wr;
      draw_if.write      = draw_busy && draw_cur.wr;
      draw_if.address    = draw_cur.addr;
      draw_if.writedata  = draw_cur.wdata;
      draw_if.byteenable = draw_cur.be;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int  n = 0;
    bit  busy;
    busy = 1;
    while (busy && n < budget) begin
      busy = (disp_q.size() != 0) || (draw_q.size() != 0) || disp_busy || draw_busy ||
             (exp_cmd_q.size() != 0) || (exp_q.size() != 0) || (pend_q.size() != 0);
      if (busy) begin
        step(1);
        n++;
      end
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_caps(input string tag, input bit draw_port, input int target, input int budget);
    int n = 0;
    while (((draw_port ? n_draw_cap : n_disp_cap) < target) && n < budget) begin
      step(1);
      n++;
    end
    check_eq(tag, (draw_port ? n_draw_cap : n_disp_cap) >= target, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main_proc
    int b, dc, wc, rb;
    int draw_pos[$];
    reset_reset_n = 1'b0;
    step(3);

    check_eq("rst_waitreq", {disp_if.waitrequest, draw_if.waitrequest}, 2'b11);
    check_eq("rst_m_rw", {m_if.read, m_if.write}, 2'b00);
    check_eq("rst_m_addr", m_if.address, 0);
    check_eq("rst_m_wdata_be", {m_if.writedata, m_if.byteenable}, 0);
    check_eq("rst_rdv", {disp_if.readdatavalid, draw_if.readdatavalid}, 2'b00);
    check_eq("rst_rdata", {disp_if.readdata, draw_if.readdata}, 0);
    check_eq("rst_underflow", rd_underflow, 0);
    reset_reset_n = 1'b1;
    step(2);

    // display-only stream, one per cycle, latency 3 downstream
    lat_chk = 1;
    b = disp_cap_cyc.size();
    for (int i = 0; i < 8; i++) disp_q.push_back('{wr: 1'b0, addr: 24'h000100 + 24'(i), wdata: '0, be: '0});
    wait_idle("t1_idle", 100);
    check_eq("t1_caps", disp_cap_cyc.size() - b, 8);
    if (disp_cap_cyc.size() >= b + 8) check_eq("t1_span", disp_cap_cyc[b+7] - disp_cap_cyc[b], 7);
    lat_chk = 0;

    // both ports continuously requesting: draw every 17th capture
    b = cap_log.size();
    for (int i = 0; i < 60; i++)
      disp_q.push_back('{wr: 1'b0, addr: 24'($urandom_range(0, 24'hFFFFFF)), wdata: '0, be: '0});
    for (int i = 0; i < 3; i++)
      draw_q.push_back('{wr: 1'b1, addr: 24'($urandom_range(0, 24'hFFFFFF)),
                         wdata: 16'($urandom), be: 2'($urandom_range(1, 3))});
    wait_idle("t2_idle", 400);
    for (int i = b; i < cap_log.size(); i++) if (cap_log[i]) draw_pos.push_back(i - b);
    check_eq("t2_draw_caps", draw_pos.size(), 3);
    for (int k = 0; k < draw_pos.size() && k < 3; k++) check_eq("t2_draw_pos", draw_pos[k], 16 + 17 * k);

    // backpressure: write held 4 cycles, refill in the accept cycle
    mwait = 1;
    draw_q.push_back('{wr: 1'b1, addr: 24'h0ABCDE, wdata: 16'hBEEF, be: 2'b01});
    wait_caps("t3_draw_cap", 1, n_draw_cap + 1, 10);
    disp_q.push_back('{wr: 1'b0, addr: 24'h000200, wdata: '0, be: '0});
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_eq("t3_m_hold", {m_if.write, m_if.read, m_if.address, m_if.writedata, m_if.byteenable},
               {1'b1, 1'b0, 24'h0ABCDE, 16'hBEEF, 2'b01});
      check_eq("t3_waitreq", {disp_if.waitrequest, draw_if.waitrequest}, 2'b11);
    end
    mwait = 0;
    step(1);
    check_eq("t3_accept_refill", {m_if.write, disp_if.read, disp_if.waitrequest}, 3'b110);
    wait_idle("t3_idle", 50);

    // pending limit: 8 reads outstanding block the 9th, a write still goes
    hold = 1;
    for (int i = 0; i < 8; i++) disp_q.push_back('{wr: 1'b0, addr: 24'h000300 + 24'(i), wdata: '0, be: '0});
    wait_caps("t4_caps8", 0, n_disp_cap + 8, 40);
    step(2);
    check_eq("t4_outstanding", pend_q.size(), 8);
    dc = n_disp_cap;
    wc = n_draw_cap;
    disp_q.push_back('{wr: 1'b0, addr: 24'h000308, wdata: '0, be: '0});
    draw_q.push_back('{wr: 1'b1, addr: 24'h000400, wdata: 16'h1234, be: 2'b11});
    step(6);
    check_eq("t4_draw_wr_issued", n_draw_cap - wc, 1);
    check_eq("t4_disp_stalled", n_disp_cap - dc, 0);
    check_eq("t4_disp_waitreq", {disp_if.read, disp_if.waitrequest}, 2'b11);
    rb = n_rdv;
    hold = 0;
    wait_caps("t4_release", 0, dc + 1, 20);
    check_eq("t4_release_after_first_return", n_rdv - rb, 1);
    wait_idle("t4_idle", 100);

    // interleaved steering, then a spurious return
    b = rdv_log.size();
    disp_q.push_back('{wr: 1'b0, addr: 24'h000500, wdata: '0, be: '0});
    wait_caps("t5_cap0", 0, n_disp_cap + 1, 10);
    draw_q.push_back('{wr: 1'b0, addr: 24'h000600, wdata: '0, be: '0});
    wait_caps("t5_cap1", 1, n_draw_cap + 1, 10);
    disp_q.push_back('{wr: 1'b0, addr: 24'h000700, wdata: '0, be: '0});
    wait_caps("t5_cap2", 0, n_disp_cap + 1, 10);
    wait_idle("t5_idle", 50);
    check_eq("t5_rdv_count", rdv_log.size() - b, 3);
    if (rdv_log.size() >= b + 3) check_eq("t5_steer", {rdv_log[b], rdv_log[b+1], rdv_log[b+2]}, 3'b010);
    check_eq("t5_no_underflow", rd_underflow, 0);
    rb = n_rdv;
    spurious = 1;
    step(1);
    spurious = 0;
    step(3);
    check_eq("t5_underflow_set", rd_underflow, 1);
    step(5);
    check_eq("t5_underflow_sticky", rd_underflow, 1);
    check_eq("t5_spurious_dropped", n_rdv - rb, 0);

    // async reset with reads outstanding and CR full
    hold = 1;
    for (int i = 0; i < 3; i++) disp_q.push_back('{wr: 1'b0, addr: 24'h000800 + 24'(i), wdata: '0, be: '0});
    wait_caps("t6_caps3", 0, n_disp_cap + 3, 20);
    step(2);
    check_eq("t6_outstanding", pend_q.size(), 3);
    mwait = 1;
    draw_q.push_back('{wr: 1'b1, addr: 24'h000900, wdata: 16'hCAFE, be: 2'b10});
    wait_caps("t6_draw_cap", 1, n_draw_cap + 1, 10);
    step(1);
    check_eq("t6_cr_full", m_if.write, 1);
    reset_reset_n = 1'b0;
    #1;
    check_eq("t6_rst_m_rw", {m_if.read, m_if.write}, 2'b00);
    check_eq("t6_rst_m_addr", m_if.address, 0);
    check_eq("t6_rst_m_wdata_be", {m_if.writedata, m_if.byteenable}, 0);
    check_eq("t6_rst_waitreq", {disp_if.waitrequest, draw_if.waitrequest}, 2'b11);
    check_eq("t6_rst_rdv_rdata", {disp_if.readdatavalid, draw_if.readdatavalid, disp_if.readdata}, 0);
    check_eq("t6_rst_underflow", rd_underflow, 0);
    step(2);
    hold = 0;
    mwait = 0;
    reset_reset_n = 1'b1;
    step(2);
    rb = n_rdv;
    disp_q.push_back('{wr: 1'b0, addr: 24'h000A00, wdata: '0, be: '0});
    wait_idle("t6_idle", 50);
    check_eq("t6_fresh_read", n_rdv - rb, 1);
    check_eq("t6_no_underflow", rd_underflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
